// File: rtl/gemm_cfg_regs.sv
// GEMM configuration register window: shadow registers, descriptor commit into a small FIFO,
// and status/readback for the bus master.
module gemm_cfg_regs #(
    parameter logic [31:0] BASE_ADDR  = 32'h9000_0000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIM_W      = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             system_bus_en,
    input  logic             system_bus_rdwr,
    input  logic [31:0]      system_bus_addr,
    input  logic [31:0]      system_bus_wr_data,
    output logic [31:0]      system_bus_rd_data,
    output logic             desc_valid,
    input  logic             desc_ready,
    output logic [31:0]      desc_a_addr,
    output logic [31:0]      desc_b_addr,
    output logic [31:0]      desc_c_addr,
    output logic [31:0]      desc_a_stride,
    output logic [31:0]      desc_b_stride,
    output logic             desc_first,
    output logic             desc_last,
    output logic [DIM_W-1:0] desc_msize,
    output logic [DIM_W-1:0] desc_ksize,
    output logic [DIM_W-1:0] desc_nsize,
    input  logic             engine_busy
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned EntryW = 5 * 32 + 2 + 3 * DIM_W;

    logic [31:0]       r_tile_a, r_tile_b, r_tile_c, r_a_stride, r_b_stride;
    logic              r_first, r_last;
    logic [1:0]        r_status;
    logic [31:0]       r_rd_data;
    logic [AW:0]       r_wptr, r_rptr;
    logic [EntryW-1:0] r_mem [FIFO_DEPTH];

    logic              w_hit, w_wr, w_rd, w_commit, w_dim_ok, w_push, w_pop;
    logic              w_full, w_empty, w_done;
    logic [2:0]        w_idx;
    logic [4:0]        w_m5, w_k5, w_n5;
    logic [AW:0]       w_count;
    logic [EntryW-1:0] w_entry, w_head;
    logic [31:0]       w_rd_val;

    assign w_hit    = (system_bus_addr[31:5] == BASE_ADDR[31:5]) && (system_bus_addr[1:0] == 2'b00);
    assign w_idx    = system_bus_addr[4:2];
    assign w_wr     = system_bus_en & system_bus_rdwr & w_hit;
    assign w_rd     = system_bus_en & ~system_bus_rdwr;
    assign w_commit = w_wr && (w_idx == 3'd6);

    assign w_m5     = system_bus_wr_data[4:0];
    assign w_k5     = system_bus_wr_data[9:5];
    assign w_n5     = system_bus_wr_data[14:10];
    assign w_dim_ok = (w_m5 != 5'd0) && (w_m5 <= 5'd16) &&
                      (w_k5 != 5'd0) && (w_k5 <= 5'd16) &&
                      (w_n5 != 5'd0) && (w_n5 <= 5'd16);

    assign w_empty  = (r_wptr == r_rptr);
    assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_count  = r_wptr - r_rptr;
    assign w_done   = w_empty & ~engine_busy;

    assign desc_valid = ~w_empty;
    assign w_pop      = desc_valid & desc_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign w_push     = w_commit & w_dim_ok & (~w_full | w_pop);

    assign w_entry = {r_tile_a, r_tile_b, r_tile_c, r_a_stride, r_b_stride, r_first, r_last,
                      DIM_W'(w_m5), DIM_W'(w_k5), DIM_W'(w_n5)};
    assign w_head  = r_mem[r_rptr[AW-1:0]];

    assign {desc_a_addr, desc_b_addr, desc_c_addr, desc_a_stride, desc_b_stride,
            desc_first, desc_last, desc_msize, desc_ksize, desc_nsize} = w_head;

    assign system_bus_rd_data = r_rd_data;

    always_comb begin
        w_rd_val = 32'd0;
        if (w_hit) begin
            case (w_idx)
                3'd0:    w_rd_val = {31'd0, w_full};
                3'd1:    w_rd_val = 32'(w_count);
                3'd2:    w_rd_val = r_tile_c;
                3'd3:    w_rd_val = r_a_stride;
                3'd4:    w_rd_val = r_b_stride;
                3'd5:    w_rd_val = {30'd0, r_first, r_last};
                3'd6:    w_rd_val = {31'd0, w_done};
                default: w_rd_val = {30'd0, r_status};
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tile_a   <= 32'd0;
            r_tile_b   <= 32'd0;
            r_tile_c   <= 32'd0;
            r_a_stride <= 32'd0;
            r_b_stride <= 32'd0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_status   <= 2'b00;
            r_rd_data  <= 32'd0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            if (w_wr) begin
                case (w_idx)
                    3'd0:    r_tile_a   <= system_bus_wr_data;
                    3'd1:    r_tile_b   <= system_bus_wr_data;
                    3'd2:    r_tile_c   <= system_bus_wr_data;
                    3'd3:    r_a_stride <= system_bus_wr_data;
                    3'd4:    r_b_stride <= system_bus_wr_data;
                    3'd5:    {r_first, r_last} <= system_bus_wr_data[1:0];
                    3'd7:    r_status   <= r_status & ~system_bus_wr_data[1:0];
                    default: ;
                endcase
            end
            if (w_commit && !w_dim_ok) begin
                r_status[1] <= 1'b1;
            end else if (w_commit && w_full && !w_pop) begin
                r_status[0] <= 1'b1;
            end
            if (w_rd) begin
                r_rd_data <= w_rd_val;
            end
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage needs no reset; validity is tracked solely by the pointers.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_entry;
        end
    end

endmodule

// File: tb/tb_gemm_cfg_regs.sv
// Directed self-checking bench for gemm_cfg_regs.
module tb_gemm_cfg_regs;

    localparam logic [31:0] BASE = 32'h9000_0000;

    logic        clk;
    logic        rst;
    logic        system_bus_en;
    logic        system_bus_rdwr;
    logic [31:0] system_bus_addr;
    logic [31:0] system_bus_wr_data;
    logic [31:0] system_bus_rd_data;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_a_addr, desc_b_addr, desc_c_addr, desc_a_stride, desc_b_stride;
    logic        desc_first, desc_last;
    logic [4:0]  desc_msize, desc_ksize, desc_nsize;
    logic        engine_busy;

    int checks = 0;
    int errors = 0;

    gemm_cfg_regs #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .DIM_W      (5)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .system_bus_en      (system_bus_en),
        .system_bus_rdwr    (system_bus_rdwr),
        .system_bus_addr    (system_bus_addr),
        .system_bus_wr_data (system_bus_wr_data),
        .system_bus_rd_data (system_bus_rd_data),
        .desc_valid         (desc_valid),
        .desc_ready         (desc_ready),
        .desc_a_addr        (desc_a_addr),
        .desc_b_addr        (desc_b_addr),
        .desc_c_addr        (desc_c_addr),
        .desc_a_stride      (desc_a_stride),
        .desc_b_stride      (desc_b_stride),
        .desc_first         (desc_first),
        .desc_last          (desc_last),
        .desc_msize         (desc_msize),
        .desc_ksize         (desc_ksize),
        .desc_nsize         (desc_nsize),
        .engine_busy        (engine_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dim(input int m, input int k, input int n);
        return 32'(m) | (32'(k) << 5) | (32'(n) << 10);
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        system_bus_en = 1'b1; system_bus_rdwr = 1'b1;
        system_bus_addr = addr; system_bus_wr_data = data;
        @(posedge clk); #1;
        system_bus_en = 1'b0; system_bus_rdwr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        system_bus_en = 1'b1; system_bus_rdwr = 1'b0; system_bus_addr = addr;
        @(posedge clk); #1;
        system_bus_en = 1'b0;
        data = system_bus_rd_data;
    endtask

    task automatic pop_one();
        @(negedge clk);
        desc_ready = 1'b1;
        @(posedge clk); #1;
        desc_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        checks++;
        if (desc_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %0b expected 0", desc_valid);
        end
        checks++;
        if (system_bus_rd_data !== 32'd0) begin
            errors++; $display("FAIL reset_rd_data: got %0h expected 0", system_bus_rd_data);
        end
        for (int i = 0; i < 8; i++) begin
            bus_read(BASE + 32'(i * 4), d);
            checks++;
            if (d !== 32'd0) begin
                errors++; $display("FAIL reset_read_idx%0d: got %0h expected 0", i, d);
            end
        end
    endtask

    task automatic test_basic_commit();
        logic [31:0] d;
        bus_write(BASE + 32'h00, 32'd0);
        bus_write(BASE + 32'h04, 32'd100);
        bus_write(BASE + 32'h08, 32'd300);
        bus_write(BASE + 32'h0C, 32'd20);
        bus_write(BASE + 32'h10, 32'd30);
        bus_write(BASE + 32'h14, 32'd3);
        bus_write(BASE + 32'h18, dim(16, 16, 4));
        checks++;
        if (desc_valid !== 1'b1) begin
            errors++; $display("FAIL basic_valid: got %0b expected 1", desc_valid);
        end
        checks++;
        if ({desc_a_addr, desc_b_addr, desc_c_addr, desc_a_stride, desc_b_stride}
            !== {32'd0, 32'd100, 32'd300, 32'd20, 32'd30}) begin
            errors++;
            $display("FAIL basic_addr: got %0d %0d %0d %0d %0d expected 0 100 300 20 30",
                     desc_a_addr, desc_b_addr, desc_c_addr, desc_a_stride, desc_b_stride);
        end
        checks++;
        if ({desc_first, desc_last, desc_msize, desc_ksize, desc_nsize}
            !== {1'b1, 1'b1, 5'd16, 5'd16, 5'd4}) begin
            errors++;
            $display("FAIL basic_fields: got f%0b l%0b m%0d k%0d n%0d expected f1 l1 m16 k16 n4",
                     desc_first, desc_last, desc_msize, desc_ksize, desc_nsize);
        end
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 32'd1) begin
            errors++; $display("FAIL basic_count: got %0d expected 1", d);
        end
        bus_read(BASE + 32'h08, d);
        checks++;
        if (d !== 32'd300) begin
            errors++; $display("FAIL basic_tile_c: got %0d expected 300", d);
        end
        bus_read(BASE + 32'h14, d);
        checks++;
        if (d !== 32'd3) begin
            errors++; $display("FAIL basic_ctrl: got %0d expected 3", d);
        end
        pop_one();
    endtask

    task automatic test_full_overflow();
        logic [31:0] d;
        for (int i = 1; i <= 4; i++) bus_write(BASE + 32'h18, dim(i, 1, 1));
        bus_read(BASE + 32'h00, d);
        checks++;
        if (d !== 32'd1) begin
            errors++; $display("FAIL full_flag: got %0d expected 1", d);
        end
        bus_write(BASE + 32'h18, dim(5, 1, 1));
        bus_read(BASE + 32'h1C, d);
        checks++;
        if (d !== 32'd1) begin
            errors++; $display("FAIL overflow_status: got %0d expected 1", d);
        end
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 32'd4) begin
            errors++; $display("FAIL overflow_count: got %0d expected 4", d);
        end
        checks++;
        if (desc_msize !== 5'd1) begin
            errors++; $display("FAIL overflow_head: got %0d expected 1", desc_msize);
        end
        bus_write(BASE + 32'h1C, 32'd1);
        bus_read(BASE + 32'h1C, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL status_w1c: got %0d expected 0", d);
        end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d;
        @(negedge clk);
        system_bus_en = 1'b1; system_bus_rdwr = 1'b1;
        system_bus_addr = BASE + 32'h18; system_bus_wr_data = dim(7, 1, 1);
        desc_ready = 1'b1;
        @(posedge clk); #1;
        system_bus_en = 1'b0; system_bus_rdwr = 1'b0; desc_ready = 1'b0;
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 32'd4) begin
            errors++; $display("FAIL pushpop_count: got %0d expected 4", d);
        end
        bus_read(BASE + 32'h1C, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL pushpop_status: got %0d expected 0", d);
        end
    endtask

    task automatic test_bad_dim();
        logic [31:0] d;
        bus_write(BASE + 32'h18, dim(1, 0, 1));
        bus_write(BASE + 32'h18, dim(1, 1, 17));
        bus_read(BASE + 32'h1C, d);
        checks++;
        if (d !== 32'd2) begin
            errors++; $display("FAIL baddim_status: got %0d expected 2", d);
        end
        bus_read(BASE + 32'h04, d);
        checks++;
        if (d !== 32'd4) begin
            errors++; $display("FAIL baddim_count: got %0d expected 4", d);
        end
        bus_write(BASE + 32'h1C, 32'd2);
    endtask

    task automatic test_done();
        logic [31:0] d;
        logic [4:0]  exp_m [4] = '{5'd2, 5'd3, 5'd4, 5'd7};
        engine_busy = 1'b0;
        bus_read(BASE + 32'h18, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL done_nonempty: got %0d expected 0", d);
        end
        engine_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (desc_msize !== exp_m[i]) begin
                errors++; $display("FAIL drain_head%0d: got %0d expected %0d", i, desc_msize, exp_m[i]);
            end
            pop_one();
        end
        checks++;
        if (desc_valid !== 1'b0) begin
            errors++; $display("FAIL drain_valid: got %0b expected 0", desc_valid);
        end
        bus_read(BASE + 32'h18, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL done_busy: got %0d expected 0", d);
        end
        @(negedge clk);
        engine_busy = 1'b0;
        bus_read(BASE + 32'h18, d);
        checks++;
        if (d !== 32'd1) begin
            errors++; $display("FAIL done_idle: got %0d expected 1", d);
        end
    endtask

    task automatic test_reset_decode();
        logic [31:0] d;
        engine_busy = 1'b1;
        bus_write(BASE + 32'h18, dim(2, 2, 2));
        bus_write(BASE + 32'h18, dim(3, 3, 3));
        checks++;
        if (desc_valid !== 1'b1) begin
            errors++; $display("FAIL prereset_valid: got %0b expected 1", desc_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (desc_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_valid: got %0b expected 0", desc_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        test_reset();
        bus_write(BASE + 32'h20, dim(4, 4, 4));
        bus_write(BASE + 32'h02, 32'hDEAD_BEEF);
        bus_write(BASE + 32'h0A, 32'd55);
        bus_write(BASE + 32'h1A, dim(4, 4, 4));
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (desc_valid !== 1'b0) begin
            errors++; $display("FAIL decode_no_commit: got %0b expected 0", desc_valid);
        end
        bus_read(BASE + 32'h08, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL decode_misaligned_wr: got %0h expected 0", d);
        end
        bus_write(BASE + 32'h0C, 32'd123);
        bus_read(BASE + 32'h0C, d);
        checks++;
        if (d !== 32'd123) begin
            errors++; $display("FAIL stride_rd: got %0d expected 123", d);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (system_bus_rd_data !== 32'd123) begin
            errors++; $display("FAIL rd_hold: got %0d expected 123", system_bus_rd_data);
        end
        bus_read(BASE + 32'h2C, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL miss_read: got %0h expected 0", d);
        end
        bus_read(BASE + 32'h0D, d);
        checks++;
        if (d !== 32'd0) begin
            errors++; $display("FAIL misaligned_read: got %0h expected 0", d);
        end
    endtask

    initial begin
        rst = 1'b0;
        system_bus_en = 1'b0; system_bus_rdwr = 1'b0;
        system_bus_addr = 32'd0; system_bus_wr_data = 32'd0;
        desc_ready = 1'b0;
        engine_busy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        test_reset();
        test_basic_commit();
        test_full_overflow();
        test_push_pop_full();
        test_bad_dim();
        test_done();
        test_reset_decode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
